// File: rtl/seq_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_frame_tx_pkg
// Brief   : Shared defaults, FSM encoding and array types for the sort-path
//           UART framers (rx/tx buffers).
// Revision: 1.0 - initial release
// ============================================================================
package seq_frame_tx_pkg;

    localparam int unsigned c_def_width    = 32;
    localparam int unsigned c_def_depth    = 8;
    localparam int unsigned c_def_num_seq  = 10;
    localparam logic [7:0]  c_def_end_byte = 8'h0A;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_load      = 3'd1;
    localparam logic [2:0] c_st_send      = 3'd2;
    localparam logic [2:0] c_st_wait_hi   = 3'd3;
    localparam logic [2:0] c_st_wait_lo   = 3'd4;
    localparam logic [2:0] c_st_term_send = 3'd5;
    localparam logic [2:0] c_st_term_hi   = 3'd6;
    localparam logic [2:0] c_st_term_lo   = 3'd7;

    // Bit 0 of an element is its MSB, so element bytes go out [0:7] first.
    typedef logic [0:c_def_width-1] elem_t;
    typedef elem_t arr_t [0:c_def_depth-1];

    function automatic int unsigned frame_bytes(input int unsigned width,
                                                input int unsigned depth);
        return (width * depth) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_fifo.sv
`default_nettype none
// ============================================================================
// Module  : seq_fifo
// Brief   : Circular FIFO of whole flattened arrays with a 1-bit sideband.
// Revision: 1.0 - initial release
// ============================================================================
module seq_fifo #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned NUM_SEQ = 10,
    parameter int unsigned CNT_W   = $clog2(NUM_SEQ + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned c_ptr_w = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;

    logic [DATA_W-1:0]  r_mem      [0:NUM_SEQ-1];
    logic               r_mem_last [0:NUM_SEQ-1];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Pushes while full are dropped without touching any state.
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == CNT_W'(NUM_SEQ));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_last  = r_mem_last[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr]      <= i_data;
            r_mem_last[r_wr_ptr] <= i_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(NUM_SEQ - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(NUM_SEQ - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : seq_frame_tx
// Brief   : Buffers arrays and serialises them MSB-byte-first to a byte UART,
//           appending END_BYTE after each batch-final array.
// Revision: 1.0 - initial release
// ============================================================================
module seq_frame_tx
    import seq_frame_tx_pkg::*;
#(
    parameter int unsigned WIDTH    = c_def_width,
    parameter int unsigned DEPTH    = c_def_depth,
    parameter int unsigned NUM_SEQ  = c_def_num_seq,
    parameter logic [7:0]  END_BYTE = c_def_end_byte
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               last_in,
    input  logic [0:WIDTH-1]   array_in [0:DEPTH-1],
    output logic               ready,
    output logic               full,
    input  logic               tx_busy,
    output logic [7:0]         byte_out,
    output logic               tx_start,
    output logic               idle
);

    localparam int unsigned c_data_w = WIDTH * DEPTH;
    localparam int unsigned c_nbytes = frame_bytes(WIDTH, DEPTH);
    localparam int unsigned c_idx_w  = $clog2(c_nbytes);
    localparam int unsigned c_cnt_w  = $clog2(NUM_SEQ + 1);

    logic [c_data_w-1:0] w_flat;
    logic [c_data_w-1:0] w_head;
    logic                w_head_last;
    logic [c_cnt_w-1:0]  w_count;
    logic                w_empty;
    logic                w_pop;

    logic [2:0]          r_state;
    logic [c_data_w-1:0] r_work;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_last;
    logic [1:0]          r_to;
    logic [7:0]          r_byte;

    // Element 0 lands in the top word so the stream shifts out from the MSB.
    for (genvar e = 0; e < DEPTH; e++) begin : g_flat
        assign w_flat[(DEPTH-e)*WIDTH-1 -: WIDTH] = array_in[e];
    end

    assign w_pop = (r_state == c_st_load);

    seq_fifo #(
        .DATA_W  (c_data_w),
        .NUM_SEQ (NUM_SEQ),
        .CNT_W   (c_cnt_w)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (valid_in),
        .i_pop   (w_pop),
        .i_data  (w_flat),
        .i_last  (last_in),
        .o_data  (w_head),
        .o_last  (w_head_last),
        .o_count (w_count),
        .o_full  (full),
        .o_empty (w_empty)
    );

    assign ready    = ~full;
    assign idle     = (r_state == c_st_idle) & w_empty;
    assign byte_out = r_byte;
    assign tx_start = ((r_state == c_st_send) | (r_state == c_st_term_send)) & ~tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_work  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_to    <= 2'd0;
            r_byte  <= 8'h00;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_count != '0) r_state <= c_st_load;
                end
                c_st_load: begin
                    r_work  <= w_head;
                    r_byte  <= w_head[c_data_w-1 -: 8];
                    r_idx   <= '0;
                    r_last  <= w_head_last;
                    r_state <= c_st_send;
                end
                c_st_send, c_st_term_send: begin
                    if (!tx_busy) begin
                        r_to    <= 2'd0;
                        r_state <= (r_state == c_st_send) ? c_st_wait_hi : c_st_term_hi;
                    end
                end
                // A transmitter that never raises busy is assumed to have taken the byte.
                c_st_wait_hi, c_st_term_hi: begin
                    if (tx_busy || (r_to == 2'd3)) begin
                        r_state <= (r_state == c_st_wait_hi) ? c_st_wait_lo : c_st_term_lo;
                    end else begin
                        r_to <= r_to + 2'd1;
                    end
                end
                c_st_wait_lo: begin
                    if (!tx_busy) begin
                        if (r_idx != c_idx_w'(c_nbytes - 1)) begin
                            r_idx   <= r_idx + 1'b1;
                            r_work  <= {r_work[c_data_w-9:0], 8'h00};
                            r_byte  <= r_work[c_data_w-9 -: 8];
                            r_state <= c_st_send;
                        end else if (r_last) begin
                            r_byte  <= END_BYTE;
                            r_state <= c_st_term_send;
                        end else if (w_count != '0) begin
                            r_state <= c_st_load;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_term_lo: begin
                    if (!tx_busy) begin
                        r_state <= (w_count != '0) ? c_st_load : c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_frame_tx
// Brief   : Directed self-checking bench for seq_frame_tx with a byte UART model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seq_frame_tx;
    import seq_frame_tx_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic       last_in;
    arr_t       array_in;
    logic       ready;
    logic       full;
    logic       tx_busy;
    logic [7:0] byte_out;
    logic       tx_start;
    logic       idle;

    logic       hold_busy;
    logic       model_busy;
    int         busy_len;
    int         busy_cnt;
    int         checks;
    int         errors;
    logic [7:0] exp_q [$];
    logic [7:0] rx_q  [$];

    seq_frame_tx dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .last_in  (last_in),
        .array_in (array_in),
        .ready    (ready),
        .full     (full),
        .tx_busy  (tx_busy),
        .byte_out (byte_out),
        .tx_start (tx_start),
        .idle     (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles after each start (0 = never busy).
    assign tx_busy = hold_busy | model_busy;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (tx_start && busy_len > 0) begin
            model_busy <= 1'b1;
            busy_cnt   <= busy_len;
        end else if (busy_cnt > 1) begin
            busy_cnt   <= busy_cnt - 1;
        end else begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end
    end

    always @(negedge clk) begin
        if (tx_start) rx_q.push_back(byte_out);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; holds the array for exactly one rising edge.
    task automatic push_arr(input logic [31:0] e0, input logic [31:0] step,
                            input logic last, input bit accept);
        array_in[0] = e0;
        for (int e = 1; e < 8; e++) array_in[e] = step * 32'(e);
        last_in  = last;
        valid_in = 1'b1;
        if (accept) begin
            for (int e = 0; e < 8; e++)
                for (int b = 0; b < 4; b++) exp_q.push_back(array_in[e][8*b +: 8]);
            if (last) exp_q.push_back(8'h0A);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (idle && rx_q.size() >= exp_q.size()) done = 1'b1;
        end
        check("done_in_budget", 32'(done), 32'd1);
        check("idle_at_end", 32'(idle), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        hold_busy = 1'b0;
        busy_len  = 10;
        for (int e = 0; e < 8; e++) array_in[e] = '0;

        #12;
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single batch-final array, 10-cycle busy per byte, plus start latency.
        push_arr(32'h01020304, 32'h0, 1'b1, 1'b1);
        lat = 1;
        while (!tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("first_start_latency", 32'(lat), 32'd3);
        check("first_byte", 32'(byte_out), 32'h01);
        wait_done(2000);
        check("single_starts", 32'(rx_q.size()), 32'd33);
        compare_stream("single");

        // Two arrays back to back, one terminator at the end only.
        busy_len = 3;
        push_arr(32'hA1B2C3D4, 32'h11111111, 1'b0, 1'b1);
        push_arr(32'h0A0A0A0A, 32'h01000003, 1'b1, 1'b1);
        wait_done(2000);
        check("pair_starts", 32'(rx_q.size()), 32'd65);
        compare_stream("pair");

        // Second push lands in the LOAD cycle of the first: count holds at 1.
        busy_len = 2;
        push_arr(32'hDEADBEEF, 32'h00000101, 1'b1, 1'b1);
        @(negedge clk);
        push_arr(32'hCAFEF00D, 32'h00020002, 1'b1, 1'b1);
        check("pushpop_full", 32'(full), 32'd0);
        check("pushpop_idle", 32'(idle), 32'd0);
        wait_done(2000);
        compare_stream("pushpop");

        // Transmitter never goes busy: every byte advances on the timeout.
        busy_len = 0;
        push_arr(32'h55AA55AA, 32'h10203040, 1'b1, 1'b1);
        wait_done(2000);
        check("timeout_starts", 32'(rx_q.size()), 32'd33);
        compare_stream("timeout");

        // Fill the FIFO while the transmitter is held busy; the first array
        // is already in the working register, so ten more fill the slots.
        busy_len  = 2;
        hold_busy = 1'b1;
        push_arr(32'h77000000, 32'h00000007, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("hold_popped_idle", 32'(idle), 32'd0);
        for (int i = 0; i < 11; i++) begin
            push_arr(32'h80000000 + 32'(i), 32'h01010101 + 32'(i), 1'b0, i < 10);
            if (i == 8) check("full_after_9", 32'(full), 32'd0);
            if (i == 9) begin
                check("full_after_10", 32'(full), 32'd1);
                check("ready_after_10", 32'(ready), 32'd0);
            end
        end
        check("hold_no_start", 32'(rx_q.size()), 32'd0);
        hold_busy = 1'b0;
        wait_done(6000);
        check("fill_starts", 32'(rx_q.size()), 32'd352);
        compare_stream("fill");

        // Reset after five bytes of a frame abandons it.
        busy_len = 10;
        push_arr(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);
        lat = 0;
        while (rx_q.size() < 5 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("five_bytes_seen", 32'(rx_q.size()), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("midrst_byte_out", 32'(byte_out), 32'h00);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_idle", 32'(idle), 32'd1);
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        rx_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_arr(32'hF1F2F3F4, 32'h00000011, 1'b1, 1'b1);
        wait_done(2000);
        compare_stream("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
